// File: rtl/pkt_input_ctrl.sv
// pkt_input_ctrl: latches packet headers, requests SRAM blocks and writes beats into linked blocks.
// Optional PKT_LEN_CHECK_EN: i_eop ends packets early and flags length mismatches on o_len_err.
module pkt_input_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int BLK_WORDS       = 16,
    parameter int BLK_ADDR_WIDTH  = 11,
    parameter int DA_WIDTH        = 4,
    parameter int PRI_WIDTH       = 3,
    parameter int LEN_WIDTH       = 10,
    parameter int PREFETCH        = 6,
    localparam int OFS_W          = $clog2(BLK_WORDS)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_sop,
    input  logic                            i_wr_vld,
    input  logic [DATA_WIDTH-1:0]           i_wr_data,
    input  logic                            i_eop,
    output logic                            o_in_rdy,
    output logic                            o_addr_req,
    input  logic                            i_blk_addr_vld,
    input  logic [BLK_ADDR_WIDTH-1:0]       i_blk_addr,
    output logic                            o_hdr_vld,
    output logic [DA_WIDTH-1:0]             o_da,
    output logic [PRI_WIDTH-1:0]            o_pri,
    output logic                            o_blk_addr_vld,
    output logic [BLK_ADDR_WIDTH-1:0]       o_blk_addr,
    output logic                            o_sram_wr,
    output logic [BLK_ADDR_WIDTH+OFS_W-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0]           o_sram_data,
    output logic                            o_pkt_done,
    output logic                            o_len_err
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = LEN_WIDTH + 1;
    localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(BLK_WORDS - 1);
    localparam logic [OFS_W-1:0] OFS_PREF = OFS_W'(BLK_WORDS - PREFETCH);

    typedef enum logic [1:0] {IDLE, WAIT_ADDR, WRITE, STALL} state_t;

    state_t                    state_q, state_d;
    logic                      rdy_en_q;
    logic [DATA_WIDTH-1:0]     hdr_q;
    logic                      hdr_eop_q;
    logic [CNT_W-1:0]          words_q, blocks_q, req_cnt_q, wr_cnt_q;
    logic [OFS_W-1:0]          ofs_q;
    logic [BLK_ADDR_WIDTH-1:0] blk_q, nxt_q;
    logic                      nxt_vld_q, req_pend_q;

    logic [LEN_WIDTH-1:0]      hdr_len;
    logic [CNT_W-1:0]          words_d, blocks_d;
    logic                      acc, gnt, hdr_acc, wr_hdr, wr, wr_eop, last, early;
    logic                      end_pkt, blk_end, pref, len_err_d, unused_eop;
    logic [BLK_ADDR_WIDTH-1:0] wr_blk;
    logic [OFS_W-1:0]          wr_ofs;
    logic [DATA_WIDTH-1:0]     wr_data;

    assign hdr_len  = i_wr_data[DA_WIDTH+PRI_WIDTH +: LEN_WIDTH];
    assign words_d  = CNT_W'(1) + ({1'b0, hdr_len} + CNT_W'(BYTES - 1)) / CNT_W'(BYTES);
    assign blocks_d = (words_d >> OFS_W) + CNT_W'(|words_d[OFS_W-1:0]);
    assign o_in_rdy = rdy_en_q && (state_q == IDLE || state_q == WRITE);

    // A grant only counts while a request is outstanding, including the cycle the request pulses.
    always_comb begin
        acc     = i_wr_vld && o_in_rdy;
        gnt     = i_blk_addr_vld && (o_addr_req || req_pend_q);
        hdr_acc = acc && i_sop && state_q == IDLE;
        wr_hdr  = state_q == WAIT_ADDR;
        wr      = wr_hdr ? gnt : (acc && state_q == WRITE);
        wr_blk  = wr_hdr ? i_blk_addr : blk_q;
        wr_ofs  = wr_hdr ? '0 : ofs_q;
        wr_data = wr_hdr ? hdr_q : i_wr_data;
        wr_eop  = wr_hdr ? hdr_eop_q : i_eop;
        last    = (wr_cnt_q + CNT_W'(1)) == words_q;
`ifdef PKT_LEN_CHECK_EN
        early      = wr_eop && !last;
        len_err_d  = early || (last && !wr_eop);
        unused_eop = 1'b0;
`else
        early      = 1'b0;
        len_err_d  = 1'b0;
        unused_eop = wr_eop;
`endif
        end_pkt = wr && (last || early);
        blk_end = wr && !end_pkt && wr_ofs == OFS_LAST;
        pref    = wr && !end_pkt && wr_ofs == OFS_PREF && req_cnt_q < blocks_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (hdr_acc) state_d = WAIT_ADDR;
            WAIT_ADDR: if (gnt) state_d = end_pkt ? IDLE : WRITE;
            WRITE:     if (end_pkt) state_d = IDLE;
                       else if (blk_end && !nxt_vld_q && !gnt) state_d = STALL;
            STALL:     if (gnt) state_d = WRITE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_en_q       <= 1'b0;
            hdr_q          <= '0;
            hdr_eop_q      <= 1'b0;
            words_q        <= '0;
            blocks_q       <= '0;
            req_cnt_q      <= '0;
            wr_cnt_q       <= '0;
            ofs_q          <= '0;
            blk_q          <= '0;
            nxt_q          <= '0;
            nxt_vld_q      <= 1'b0;
            req_pend_q     <= 1'b0;
            o_addr_req     <= 1'b0;
            o_hdr_vld      <= 1'b0;
            o_da           <= '0;
            o_pri          <= '0;
            o_blk_addr_vld <= 1'b0;
            o_blk_addr     <= '0;
            o_sram_wr      <= 1'b0;
            o_sram_addr    <= '0;
            o_sram_data    <= '0;
            o_pkt_done     <= 1'b0;
            o_len_err      <= 1'b0;
        end else begin
            rdy_en_q       <= 1'b1;
            o_hdr_vld      <= 1'b0;
            o_addr_req     <= 1'b0;
            o_blk_addr_vld <= 1'b0;
            o_sram_wr      <= 1'b0;
            o_pkt_done     <= 1'b0;
            o_len_err      <= 1'b0;
            req_pend_q     <= (req_pend_q || o_addr_req) && !gnt;
            if (hdr_acc) begin
                hdr_q      <= i_wr_data;
                hdr_eop_q  <= i_eop;
                o_da       <= i_wr_data[DA_WIDTH-1:0];
                o_pri      <= i_wr_data[DA_WIDTH +: PRI_WIDTH];
                o_hdr_vld  <= 1'b1;
                o_addr_req <= 1'b1;
                words_q    <= words_d;
                blocks_q   <= blocks_d;
                req_cnt_q  <= CNT_W'(1);
                wr_cnt_q   <= '0;
                nxt_vld_q  <= 1'b0;
            end
            if (wr) begin
                o_sram_wr      <= 1'b1;
                o_sram_addr    <= {wr_blk, wr_ofs};
                o_sram_data    <= wr_data;
                o_blk_addr_vld <= wr_ofs == '0;
                o_pkt_done     <= end_pkt;
                o_len_err      <= len_err_d;
                wr_cnt_q       <= wr_cnt_q + CNT_W'(1);
                blk_q          <= wr_blk;
                ofs_q          <= wr_ofs + OFS_W'(1);
                if (wr_ofs == '0) o_blk_addr <= wr_blk;
            end
            if (pref) begin
                o_addr_req <= 1'b1;
                req_cnt_q  <= req_cnt_q + CNT_W'(1);
            end
            // Early grants park in the next-block register until the current block fills.
            if (gnt && state_q == WRITE && !blk_end) begin
                nxt_q     <= i_blk_addr;
                nxt_vld_q <= 1'b1;
            end
            if (blk_end) begin
                blk_q     <= nxt_vld_q ? nxt_q : i_blk_addr;
                nxt_vld_q <= 1'b0;
            end
            if (gnt && state_q == STALL) blk_q <= i_blk_addr;
            if (end_pkt) nxt_vld_q <= 1'b0;
        end
    end
endmodule
